// File: rtl/result_writer_nn.sv
// result_writer_nn: saturating pairwise reduction of MAC lanes, FIFO-buffered write-back to output BRAM.
module result_writer_nn #(
  parameter int ACC_W      = 16,
  parameter int N          = 4,
  parameter int N_MACS     = 4,
  parameter int MEM_DEPTH  = 256,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic [ACC_W-1:0]                        acc_in_0,
  input  logic [ACC_W-1:0]                        acc_in_1,
  input  logic [ACC_W-1:0]                        acc_in_2,
  input  logic [ACC_W-1:0]                        acc_in_3,
  input  logic [N_MACS-1:0]                       valid_in,
  input  logic [((N/2 > 1) ? $clog2(N/2) : 1)-1:0] row_tile_in,
  output logic [$clog2(MEM_DEPTH)-1:0]            out_bram_addr,
  output logic                                    out_bram_en,
  output logic                                    out_bram_we,
  output logic [ACC_W-1:0]                        out_bram_din,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    overflow,
  output logic                                    lane_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int PW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] LIM = CW'(FIFO_DEPTH - 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, nxt;
  logic [AW-1:0] fa [FIFO_DEPTH];
  logic [ACC_W-1:0] fd [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] cnt;
  logic [15:0] tally;
  logic complete, pop, cap, accept, drop, partial;
  logic [AW-1:0] ea;
  logic [ACC_W-1:0] y0, y1;
  function automatic logic [ACC_W-1:0] sat(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    return (s[ACC_W] != s[ACC_W-1]) ? {s[ACC_W], {(ACC_W-1){~s[ACC_W]}}} : s[ACC_W-1:0];
  endfunction
  always_comb begin
    complete = (tally >= 16'(N)) && (cnt == '0);
    pop      = (st == RUN) && (cnt != '0);
    cap      = (st == RUN) && !complete && (valid_in == '1);
    partial  = (st == RUN) && (valid_in != '0) && (valid_in != '1);
    // room is judged after this cycle's pop; a tile needs two slots
    accept   = cap && ((cnt - CW'(pop)) <= LIM);
    drop     = cap && !accept;
    ea       = AW'(BASE_ADDR) + AW'({row_tile_in, 1'b0});
    y0       = sat(acc_in_0, acc_in_1);
    y1       = sat(acc_in_2, acc_in_3);
    nxt      = (st == IDLE && start) ? RUN :
               (st == RUN && complete) ? DONE :
               (st == DONE) ? IDLE : st;
    busy     = (st == RUN);
    done     = (st == DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      st            <= IDLE;
      wp            <= '0;
      rp            <= '0;
      cnt           <= '0;
      tally         <= '0;
      overflow      <= 1'b0;
      lane_err      <= 1'b0;
      out_bram_en   <= 1'b0;
      out_bram_we   <= 1'b0;
      out_bram_addr <= '0;
      out_bram_din  <= '0;
    end else begin
      st          <= nxt;
      out_bram_en <= pop;
      out_bram_we <= pop;
      if (pop) begin
        out_bram_addr <= fa[rp];
        out_bram_din  <= fd[rp];
        rp            <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + PW'(1);
      end
      // pairs always land on even slots, so wrapping by two stays aligned
      if (accept) wp <= (wp == PW'(FIFO_DEPTH - 2)) ? '0 : wp + PW'(2);
      cnt <= cnt + (accept ? CW'(2) : '0) - CW'(pop);
      if (st == IDLE && start) begin
        tally    <= '0;
        overflow <= 1'b0;
        lane_err <= 1'b0;
      end else begin
        tally    <= tally + 16'(pop) + (drop ? 16'd2 : 16'd0);
        overflow <= overflow | drop;
        lane_err <= lane_err | partial;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      fa[wp]          <= ea;
      fd[wp]          <= y0;
      fa[wp + PW'(1)] <= ea + AW'(1);
      fd[wp + PW'(1)] <= y1;
    end
  end
endmodule

// File: tb/tb_result_writer_nn.sv
// tb_result_writer_nn: scoreboard bench for result_writer_nn (N=4, BASE_ADDR=16, FIFO_DEPTH=2).
module tb_result_writer_nn;
  logic clk = 0, rst = 0, start = 0;
  logic [15:0] a0 = 0, a1 = 0, a2 = 0, a3 = 0;
  logic [3:0] valid_in = 0;
  logic [0:0] row_tile_in = 0;
  logic [7:0] out_bram_addr;
  logic out_bram_en, out_bram_we, busy, done, overflow, lane_err;
  logic [15:0] out_bram_din;
  int checks = 0, errors = 0, cyc = 0, last_we = 0, done_n = 0;
  logic [23:0] q[$];
  logic [23:0] e;
  result_writer_nn #(.ACC_W(16), .N(4), .N_MACS(4), .MEM_DEPTH(256), .BASE_ADDR(16), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3),
    .valid_in(valid_in), .row_tile_in(row_tile_in),
    .out_bram_addr(out_bram_addr), .out_bram_en(out_bram_en), .out_bram_we(out_bram_we),
    .out_bram_din(out_bram_din), .busy(busy), .done(done), .overflow(overflow), .lane_err(lane_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] sat(input logic [15:0] x, input logic [15:0] y);
    int s;
    s = int'($signed(x)) + int'($signed(y));
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s[15:0];
  endfunction
  always @(negedge clk) begin
    if (done) done_n++;
    if (out_bram_we) begin
      last_we = cyc;
      if (q.size() == 0) chk("wr_unexpected", 32'(q.size()), 1);
      else begin
        e = q.pop_front();
        chk("wr_addr", 32'(out_bram_addr), 32'(e[23:16]));
        chk("wr_data", 32'(out_bram_din), 32'(e[15:0]));
      end
    end
  end
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic cap(input int t, input logic [15:0] x0, x1, x2, x3, input bit exp);
    a0 = x0; a1 = x1; a2 = x2; a3 = x3;
    row_tile_in = 1'(t);
    valid_in = 4'b1111;
    if (exp) begin
      q.push_back({8'(16 + 2 * t), sat(x0, x1)});
      q.push_back({8'(17 + 2 * t), sat(x2, x3)});
    end
    @(negedge clk);
  endtask
  task automatic idle(input int n);
    valid_in = 0;
    repeat (n) @(negedge clk);
  endtask
  task automatic wait_done(input string tag);
    int k;
    valid_in = 0;
    for (k = 0; k < 40 && !done; k++) @(negedge clk);
    if (!done) chk({tag, "_timeout"}, 0, 1);
    else chk({tag, "_done_lat"}, 32'(cyc), 32'(last_we + 1));
    chk({tag, "_q_empty"}, 32'(q.size()), 0);
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_done_1cyc"}, 32'(done), 0);
  endtask
  initial begin
    int k;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(out_bram_en), 0);
    chk("rst_we", 32'(out_bram_we), 0);
    chk("rst_addr", 32'(out_bram_addr), 0);
    chk("rst_din", 32'(out_bram_din), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_lerr", 32'(lane_err), 0);
    rst = 1;
    @(negedge clk);
    cap(0, 16'd9, 16'd9, 16'd9, 16'd9, 0);
    idle(4);
    chk("idle_busy", 32'(busy), 0);
    pulse_start();
    chk("start_busy", 32'(busy), 1);
    cap(0, 16'd1, 16'd2, 16'd3, 16'd4, 1);
    idle(3);
    pulse_start();
    cap(1, 16'd10, -16'sd4, 16'd5, 16'd5, 1);
    wait_done("basic");
    pulse_start();
    cap(0, 16'h7000, 16'h7000, 16'h8000, 16'hFFFF, 1);
    idle(3);
    cap(1, 16'h7FFF, 16'h0001, 16'h8000, 16'h8000, 1);
    wait_done("sat");
    pulse_start();
    cap(0, 16'd1, 16'd1, 16'd1, 16'd1, 1);
    cap(1, 16'd100, 16'd0, 16'd200, 16'd0, 0);
    cap(1, 16'd5, 16'd6, 16'd7, 16'd8, 1);
    valid_in = 0;
    chk("ovf_set", 32'(overflow), 1);
    wait_done("ovf");
    chk("ovf_sticky", 32'(overflow), 1);
    pulse_start();
    chk("ovf_cleared", 32'(overflow), 0);
    a0 = 16'd7;
    valid_in = 4'b0011;
    @(negedge clk);
    chk("lerr_set", 32'(lane_err), 1);
    idle(3);
    cap(0, -16'sd3, 16'd1, 16'd2, -16'sd5, 1);
    idle(3);
    cap(1, 16'd4, 16'd4, 16'd8, 16'd8, 1);
    wait_done("lerr");
    chk("lerr_sticky", 32'(lane_err), 1);
    pulse_start();
    chk("lerr_cleared", 32'(lane_err), 0);
    cap(1, 16'd11, 16'd22, 16'd33, 16'd44, 1);
    valid_in = 0;
    for (k = 0; k < 10 && !out_bram_we; k++) @(negedge clk);
    chk("rst_first_wr", 32'(out_bram_we), 1);
    rst = 0;
    @(negedge clk);
    rst = 1;
    chk("rst_discard", 32'(q.size()), 1);
    if (q.size() != 0) void'(q.pop_back());
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_we", 32'(out_bram_we), 0);
    idle(10);
    chk("done_count", 32'(done_n), 4);
    chk("final_q_empty", 32'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
